// File: rtl/jamma_input_scan_pkg.sv
// Shared sizing helpers and legal parameter ranges for the JAMMA input scanner.
package jamma_input_scan_pkg;

    localparam int NUM_PLAYERS_MIN = 2;
    localparam int NUM_PLAYERS_MAX = 4;
    localparam int SETTLE_MIN      = 0;
    localparam int SETTLE_MAX      = 255;
    localparam int DEBOUNCE_MIN    = 1;
    localparam int DEBOUNCE_MAX    = 15;

    // Slot counter is sized for the largest legal SETTLE so every configuration shares one width.
    localparam int SLOT_W = 8;

    // Width of the player-select index driven to the external multiplexer.
    function automatic int sel_width(input int num_players);
        return (num_players > 1) ? $clog2(num_players) : 1;
    endfunction

    // Width of a per-bit debounce counter able to hold 0..debounce.
    function automatic int debounce_width(input int debounce);
        return $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/jamma_input_scan_debounce_bit.sv
// One debounced joystick bit: flips only after DEBOUNCE consecutive disagreeing samples.
module jamma_debounce_bit
    import jamma_input_scan_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic I_CLK,
    input  logic I_RESET_N,
    input  logic I_SAMPLE_EN,
    input  logic I_SAMPLE,
    output logic O_Q
);

    localparam int               CNT_W    = debounce_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] cnt;

    // Agreeing samples clear the run; the DEBOUNCE-th disagreeing sample in a row flips the output.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            O_Q <= 1'b1;
            cnt <= '0;
        end else if (I_SAMPLE_EN) begin
            if (I_SAMPLE == O_Q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                O_Q <= ~O_Q;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jamma_input_scan.sv
// Multiplexed JAMMA joystick scanner with per-bit debounce and independent coin stretchers.
module jamma_input_scan
    import jamma_input_scan_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int JOY_BITS     = 8,
    parameter int SETTLE       = 3,
    parameter int DEBOUNCE     = 4,
    parameter int COIN_STRETCH = 16
) (
    input  logic                              I_CLK,
    input  logic                              I_RESET_N,
    input  logic [JOY_BITS-1:0]               I_JJOY,
    input  logic [JOY_BITS-1:0]               I_LOCAL_JOY,
    input  logic [NUM_PLAYERS-1:0]            I_COIN_N,
    output logic [sel_width(NUM_PLAYERS)-1:0] O_JSELECT,
    output logic [NUM_PLAYERS*JOY_BITS-1:0]   O_JOY,
    output logic [NUM_PLAYERS-1:0]            O_COIN_N,
    output logic                              O_SCAN_DONE
);

    localparam int                SEL_W     = sel_width(NUM_PLAYERS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_PLAYERS - 1);
    localparam int                STR_W     = $clog2(COIN_STRETCH + 1);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(COIN_STRETCH - 1);

    if (NUM_PLAYERS < NUM_PLAYERS_MIN || NUM_PLAYERS > NUM_PLAYERS_MAX) begin : g_bad_players
        $error("jamma_input_scan: NUM_PLAYERS out of range");
    end
    if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_settle
        $error("jamma_input_scan: SETTLE out of range");
    end
    if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_debounce
        $error("jamma_input_scan: DEBOUNCE out of range");
    end

    logic [SLOT_W-1:0]      slot_cnt;
    logic                   sample_en;
    logic [JOY_BITS-1:0]    sample_bus;
    logic [NUM_PLAYERS-1:0] coin_meta;
    logic [NUM_PLAYERS-1:0] coin_sync;
    logic [NUM_PLAYERS-1:0] coin_prev;

    // The bus has settled on the last clock of the slot; that is the only clock it is sampled.
    assign sample_en = (slot_cnt == SLOT_LAST);

    // Slot timing, round-robin player select and the end-of-cycle strobe.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            slot_cnt    <= '0;
            O_JSELECT   <= '0;
            O_SCAN_DONE <= 1'b0;
        end else begin
            O_SCAN_DONE <= sample_en && (O_JSELECT == SEL_LAST);
            if (sample_en) begin
                slot_cnt  <= '0;
                O_JSELECT <= (O_JSELECT == SEL_LAST) ? '0 : O_JSELECT + SEL_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Player 0 also sees the cabinet-local stick; both are active low, so AND merges presses.
    always_comb begin
        sample_bus = I_JJOY;
        if (O_JSELECT == '0) begin
            sample_bus = I_JJOY & I_LOCAL_JOY;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic player_en;
        assign player_en = sample_en && (O_JSELECT == SEL_W'(p));

        for (genvar b = 0; b < JOY_BITS; b++) begin : g_bit
            jamma_debounce_bit #(
                .DEBOUNCE (DEBOUNCE)
            ) u_debounce_bit (
                .I_CLK       (I_CLK),
                .I_RESET_N   (I_RESET_N),
                .I_SAMPLE_EN (player_en),
                .I_SAMPLE    (sample_bus[b]),
                .O_Q         (O_JOY[p*JOY_BITS + b])
            );
        end
    end

    // Two-flop synchroniser for the asynchronous coin switches, plus a delayed copy for edge detect.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            coin_meta <= '1;
            coin_sync <= '1;
            coin_prev <= '1;
        end else begin
            coin_meta <= I_COIN_N;
            coin_sync <= coin_meta;
            coin_prev <= coin_sync;
        end
    end

    for (genvar c = 0; c < NUM_PLAYERS; c++) begin : g_coin
        logic             coin_fall;
        logic [STR_W-1:0] stretch_cnt;
        logic             coin_out_n;

        assign coin_fall   = coin_prev[c] & ~coin_sync[c];
        assign O_COIN_N[c] = coin_out_n;

        // A fresh falling edge (re)loads the stretch; output stays low while stretching or held low.
        always_ff @(posedge I_CLK) begin
            if (!I_RESET_N) begin
                stretch_cnt <= '0;
                coin_out_n  <= 1'b1;
            end else begin
                if (coin_fall) begin
                    stretch_cnt <= STR_LOAD;
                end else if (stretch_cnt != '0) begin
                    stretch_cnt <= stretch_cnt - STR_W'(1);
                end
                coin_out_n <= ~(coin_fall || (stretch_cnt != '0) || !coin_sync[c]);
            end
        end
    end

endmodule

// File: tb/tb_jamma_input_scan.sv
// Bench for jamma_input_scan: two configurations checked every cycle against a behavioural
// model, plus directed scenarios for scan order, debounce, local merge, coin stretch and reset.
module tb_jamma_input_scan;

    localparam int NP0 = 2, S0 = 3, D0 = 4, CS0 = 16;
    localparam int NP1 = 3, S1 = 0, D1 = 2, CS1 = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     jjoy0, ljoy0, jjoy1, ljoy1;
    logic [NP0-1:0] coin0, cout0;
    logic [NP1-1:0] coin1, cout1;
    logic [0:0]     jsel0;
    logic [1:0]     jsel1;
    logic [NP0*8-1:0] joy0;
    logic [NP1*8-1:0] joy1;
    logic           done0, done1;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_en = 1'b0;

    logic [7:0] pdat0 [NP0];
    logic [7:0] pdat1 [NP1];

    // Behavioural model state, one set per configuration.
    int         m_cyc   [2];          // clocks since reset release
    logic [7:0] m_joy   [2][4];       // debounced value per player
    int         m_run   [2][4][8];    // consecutive samples disagreeing with the debounced bit
    bit         m_done  [2];
    bit         m_hist  [2][4][4];    // raw coin samples: [0] newest .. [3] three clocks old
    int         m_since [2][4];       // clocks since the last coin fall seen through the sync delay

    always #5 clk = ~clk;

    jamma_input_scan #(
        .NUM_PLAYERS(NP0), .JOY_BITS(8), .SETTLE(S0), .DEBOUNCE(D0), .COIN_STRETCH(CS0)
    ) dut0 (
        .I_CLK(clk), .I_RESET_N(rst_n), .I_JJOY(jjoy0), .I_LOCAL_JOY(ljoy0), .I_COIN_N(coin0),
        .O_JSELECT(jsel0), .O_JOY(joy0), .O_COIN_N(cout0), .O_SCAN_DONE(done0)
    );

    jamma_input_scan #(
        .NUM_PLAYERS(NP1), .JOY_BITS(8), .SETTLE(S1), .DEBOUNCE(D1), .COIN_STRETCH(CS1)
    ) dut1 (
        .I_CLK(clk), .I_RESET_N(rst_n), .I_JJOY(jjoy1), .I_LOCAL_JOY(ljoy1), .I_COIN_N(coin1),
        .O_JSELECT(jsel1), .O_JOY(joy1), .O_COIN_N(cout1), .O_SCAN_DONE(done1)
    );

    function automatic int p_np(input int u); return (u == 0) ? NP0 : NP1; endfunction
    function automatic int p_s (input int u); return (u == 0) ? S0  : S1;  endfunction
    function automatic int p_d (input int u); return (u == 0) ? D0  : D1;  endfunction
    function automatic int p_cs(input int u); return (u == 0) ? CS0 : CS1; endfunction

    function automatic int exp_jsel(input int u);
        return (m_cyc[u] / (p_s(u) + 1)) % p_np(u);
    endfunction

    function automatic bit is_sample(input int u);
        return (m_cyc[u] % (p_s(u) + 1)) == p_s(u);
    endfunction

    function automatic logic [31:0] exp_joy(input int u);
        logic [31:0] v = '0;
        for (int p = 0; p < p_np(u); p++) v[p*8 +: 8] = m_joy[u][p];
        return v;
    endfunction

    function automatic logic [3:0] exp_coin(input int u);
        logic [3:0] v = '0;
        for (int c = 0; c < p_np(u); c++)
            v[c] = !(!m_hist[u][c][2] || (m_since[u][c] < p_cs(u)));
        return v;
    endfunction

    task automatic model_step(input int u, input logic [7:0] jj, input logic [7:0] lj,
                              input logic [3:0] coin, input logic rst_v);
        int pl;
        bit smp, sb;
        if (!rst_v) begin
            m_cyc[u]  = 0;
            m_done[u] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                m_joy[u][p] = 8'hFF;
                for (int b = 0; b < 8; b++) m_run[u][p][b] = 0;
                for (int i = 0; i < 4; i++) m_hist[u][p][i] = 1'b1;
                m_since[u][p] = 1000;
            end
        end else begin
            pl  = exp_jsel(u);
            smp = is_sample(u);
            m_done[u] = smp && (pl == p_np(u) - 1);
            if (smp) begin
                for (int b = 0; b < 8; b++) begin
                    sb = jj[b] & ((pl == 0) ? lj[b] : 1'b1);
                    if (sb == m_joy[u][pl][b]) begin
                        m_run[u][pl][b] = 0;
                    end else begin
                        m_run[u][pl][b]++;
                        if (m_run[u][pl][b] >= p_d(u)) begin
                            m_joy[u][pl][b] = sb;
                            m_run[u][pl][b] = 0;
                        end
                    end
                end
            end
            m_cyc[u]++;
            for (int c = 0; c < p_np(u); c++) begin
                m_hist[u][c][3] = m_hist[u][c][2];
                m_hist[u][c][2] = m_hist[u][c][1];
                m_hist[u][c][1] = m_hist[u][c][0];
                m_hist[u][c][0] = coin[c];
                if (m_hist[u][c][3] && !m_hist[u][c][2]) m_since[u][c] = 0;
                else if (m_since[u][c] < 1000) m_since[u][c]++;
            end
        end
    endtask

    // Advance the model on the same edge the DUTs see; inputs only move at negedges.
    always @(posedge clk) begin
        model_step(0, jjoy0, ljoy0, {2'b11, coin0}, rst_n);
        model_step(1, jjoy1, ljoy1, {1'b1, coin1}, rst_n);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check_eq("jsel0", jsel0, exp_jsel(0));
        check_eq("done0", done0, m_done[0]);
        check_eq("joy0",  joy0,  exp_joy(0));
        check_eq("coin0", cout0, exp_coin(0));
        check_eq("jsel1", jsel1, exp_jsel(1));
        check_eq("done1", done1, m_done[1]);
        check_eq("joy1",  joy1,  exp_joy(1));
        check_eq("coin1", cout1, exp_coin(1));
    endtask

    // Emulate the external mux: on the sample clock the bus carries the selected player,
    // otherwise it carries junk that must never be captured.
    task automatic apply_inputs();
        jjoy0 = is_sample(0) ? pdat0[exp_jsel(0)] : 8'($urandom);
        jjoy1 = is_sample(1) ? pdat1[exp_jsel(1)] : 8'($urandom);
    endtask

    task automatic random_step();
        int p, b;
        if ($urandom_range(0, 5) == 0) begin
            p = $urandom_range(0, NP0 - 1); b = $urandom_range(0, 7);
            pdat0[p][b] = ~pdat0[p][b];
        end
        if ($urandom_range(0, 5) == 0) begin
            p = $urandom_range(0, NP1 - 1); b = $urandom_range(0, 7);
            pdat1[p][b] = ~pdat1[p][b];
        end
        if ($urandom_range(0, 63) == 0) begin b = $urandom_range(0, 7); ljoy0[b] = ~ljoy0[b]; end
        if ($urandom_range(0, 63) == 0) begin b = $urandom_range(0, 7); ljoy1[b] = ~ljoy1[b]; end
        for (int c = 0; c < NP0; c++) if ($urandom_range(0, 9) == 0) coin0[c] = ~coin0[c];
        for (int c = 0; c < NP1; c++) if ($urandom_range(0, 3) == 0) coin1[c] = ~coin1[c];
        rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        if (rand_en) random_step();
        apply_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int seq2 [9];
        int seq3 [4];
        int first, len;
        seq2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        seq3 = '{0, 1, 2, 0};
        rst_n = 1'b0;
        jjoy0 = '1; ljoy0 = '1; jjoy1 = '1; ljoy1 = '1;
        coin0 = '1; coin1 = '1;
        for (int p = 0; p < NP0; p++) pdat0[p] = 8'hFF;
        for (int p = 0; p < NP1; p++) pdat1[p] = 8'hFF;

        // Reset values and default scan order.
        do_reset();
        check_eq("rst_joy0",  joy0,  {NP0*8{1'b1}});
        check_eq("rst_coin0", cout0, {NP0{1'b1}});
        check_eq("rst_done0", done0, 1'b0);
        check_eq("seq_jsel", jsel0, seq2[0]);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("seq_jsel", jsel0, seq2[i]);
            check_eq("seq_done", done0, (i == 8));
        end

        // Three players, no settle: one sample per clock.
        do_reset();
        check_eq("p3_jsel", jsel1, seq3[0]);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("p3_jsel", jsel1, seq3[i]);
        end
        check_eq("p3_done", done1, 1'b1);

        // Four qualifying player-0 samples make bit 0 fall.
        do_reset();
        pdat0[0] = 8'hFE; apply_inputs();
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (k == 27) check_eq("deb_hold3", joy0[0], 1'b1);
            if (k == 28) check_eq("deb_fall4", joy0[0], 1'b0);
        end
        check_eq("deb_p1", joy0[15:8], 8'hFF);

        // A three-sample glitch is rejected.
        do_reset();
        pdat0[0] = 8'hFE; apply_inputs();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 19) pdat0[0] = 8'hFF;
            if (k == 28 || k == 60) check_eq("deb_glitch", joy0[7:0], 8'hFF);
        end

        // Local stick merges into player 0 only.
        do_reset();
        ljoy0 = 8'hFD; apply_inputs();
        repeat (40) tick();
        check_eq("merge_p0", joy0[7:0],  8'hFD);
        check_eq("merge_p1", joy0[15:8], 8'hFF);
        ljoy0 = 8'hFF;

        // Two-clock coin pulse stretched to sixteen clocks.
        do_reset();
        coin0[1] = 1'b0;
        first = -1; len = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2) coin0[1] = 1'b1;
            if (cout0[1] == 1'b0) begin
                if (first < 0) first = k;
                len++;
            end
        end
        check_eq("coin_start", first, 3);
        check_eq("coin_len", len, 16);

        // Second pulse ten clocks later retriggers the stretch.
        do_reset();
        coin0[1] = 1'b0;
        len = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 2 || k == 12) coin0[1] = 1'b1;
            if (k == 10) coin0[1] = 1'b0;
            if (cout0[1] == 1'b0) len++;
        end
        check_eq("coin_retrig_len", len, 26);

        // Reset mid-slot and mid-stretch with player 0 fully pressed.
        do_reset();
        pdat0[0] = 8'h00; apply_inputs();
        repeat (41) tick();
        check_eq("rst_pre_joy", joy0[7:0], 8'h00);
        coin0[0] = 1'b0;
        repeat (3) tick();
        coin0[0] = 1'b1;
        tick();
        check_eq("rst_pre_coin", cout0[0], 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_mid_joy",  joy0,  {NP0*8{1'b1}});
        check_eq("rst_mid_coin", cout0, {NP0{1'b1}});
        check_eq("rst_mid_jsel", jsel0, 1'b0);
        check_eq("rst_mid_done", done0, 1'b0);
        pdat0[0] = 8'hFF;

        // Randomized run against the model, with occasional resets.
        rand_en = 1'b1;
        repeat (3000) tick();
        rand_en = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jamma_input_scan.md
JAMMA_INPUT_SCAN -- requirements
Module: jamma_input_scan

Interface
REQ-001 The module SHALL take parameter NUM_PLAYERS, default 2, meaning the number of multiplexed player ports, legal range 2..4.
REQ-002 The module SHALL take parameter JOY_BITS, default 8, meaning the width of the shared JJOY bus per player.
REQ-003 The module SHALL take parameter SETTLE, default 3, meaning the idle clocks after a select change before the bus is sampled; legal range 0..255.
REQ-004 The module SHALL take parameter DEBOUNCE, default 4, meaning the number of consecutive equal samples needed to change a debounced bit; legal range 1..15.
REQ-005 The module SHALL take parameter COIN_STRETCH, default 16, meaning the minimum width in clocks of an output coin pulse.
REQ-006 The module SHALL have I_CLK, input, 1 bit: the single clock, rising edge.
REQ-007 The module SHALL have I_RESET_N, input, 1 bit: synchronous, active-low reset.
REQ-008 The module SHALL have I_JJOY, input, JOY_BITS: the shared active-low JAMMA bus.
REQ-009 The module SHALL have I_LOCAL_JOY, input, JOY_BITS: an active-low local joystick that is ANDed into player 0 only.
REQ-010 The module SHALL have I_COIN_N, input, NUM_PLAYERS: asynchronous, active-low coin switches.
REQ-011 The module SHALL have O_JSELECT, output, clog2(NUM_PLAYERS): the player-select index driven to the external multiplexer.
REQ-012 The module SHALL have O_JOY, output, NUM_PLAYERS*JOY_BITS: the debounced active-low joysticks, with player p at bits [p*JOY_BITS +: JOY_BITS].
REQ-013 The module SHALL have O_COIN_N, output, NUM_PLAYERS: the synchronised, stretched active-low coin signals.
REQ-014 The module SHALL have O_SCAN_DONE, output, 1 bit: a one-clock strobe marking the completion of a full player cycle.

Function
REQ-015 A slot counter SHALL count 0..SETTLE; each player slot SHALL last SETTLE+1 clocks.
REQ-016 O_JSELECT SHALL advance by 1 on the clock after the slot counter equals SETTLE, and SHALL wrap from NUM_PLAYERS-1 to 0.
REQ-017 I_JJOY SHALL be sampled only on the clock where the slot counter equals SETTLE, for the player currently shown on O_JSELECT.
REQ-018 The sample for player 0 SHALL be I_JJOY AND I_LOCAL_JOY; samples for all other players SHALL be I_JJOY only.
REQ-019 Each debounced bit SHALL have a saturating counter of width clog2(DEBOUNCE+1).
REQ-020 A sample equal to the current debounced bit SHALL clear that bit's counter.
REQ-021 A sample differing from the current debounced bit SHALL increment that bit's counter; when the count reaches DEBOUNCE, the debounced bit SHALL flip and the counter SHALL clear.
REQ-022 With DEBOUNCE=1, the debounced bit SHALL follow the sample with one clock of latency.
REQ-023 Latency from sample clock to an O_JOY change SHALL be exactly 1 clock on the qualifying sample.
REQ-024 O_JOY bits for a player SHALL change only on that player's sample clock and SHALL hold at all other times.
REQ-025 O_SCAN_DONE SHALL pulse high for 1 clock, on the clock after the sample of player NUM_PLAYERS-1.
REQ-026 I_COIN_N SHALL pass through a 2-flop synchroniser per bit.
REQ-027 A synchronised falling edge on a coin input SHALL drive the matching O_COIN_N low and load a stretch counter with COIN_STRETCH-1.
REQ-028 O_COIN_N SHALL stay low while the stretch counter is non-zero OR the synchronised input is low, and SHALL return high otherwise.
REQ-029 A new falling edge during a stretch SHALL reload the stretch counter (retrigger).
REQ-030 Coin channels SHALL be independent; simultaneous edges on several channels SHALL each be handled.
REQ-031 The coin path SHALL NOT depend on the scan timing.

Reset
REQ-032 While I_RESET_N=0 on a clock edge, O_JSELECT SHALL become 0, the slot counter 0, all debounce counters 0, all O_JOY bits 1, all O_COIN_N bits 1, all stretch counters 0, O_SCAN_DONE 0, and the synchroniser flops 1.
REQ-033 A reset asserted mid-slot or mid-stretch SHALL abort that activity; the first sample after release SHALL be player 0 at clock SETTLE+1.

Structure
REQ-034 A shared package SHALL hold the legal parameter ranges and the function that computes the select width.
REQ-035 The per-bit debounce logic SHALL be one sub-module, jamma_debounce_bit, instantiated NUM_PLAYERS*JOY_BITS times.

Verification
REQ-036 Scan timing: with defaults, O_JSELECT SHALL read 0,0,0,0,1,1,1,1,0 and O_SCAN_DONE SHALL pulse at clock 8 after reset release.
REQ-037 Debounce: holding I_JJOY=8'hFE for 4 player-0 samples SHALL make O_JOY[0] fall after the 4th sample; a glitch lasting 3 samples SHALL leave O_JOY[0]=1.
REQ-038 Local merge: I_LOCAL_JOY=8'hFD with I_JJOY=8'hFF SHALL give player 0 = 8'hFD and player 1 = 8'hFF after debounce.
REQ-039 Coin: a 2-clock low pulse on I_COIN_N[1] SHALL produce an O_COIN_N[1] low of exactly 16 clocks, starting 3 clocks after the pulse; a second pulse 10 clocks later SHALL extend the low to 26 clocks.
REQ-040 Reset mid-operation: asserting I_RESET_N=0 for 1 clock while O_JOY=8'h00 SHALL drive all outputs to their REQ-032 values on the next clock.
REQ-041 Parameter sweep: NUM_PLAYERS=3 with SETTLE=0 SHALL produce O_JSELECT 0,1,2,0 with one sample per clock.
